jtsdram_bank_arb: RTL and testbench
===================================

Name: jtsdram_bank_arb

Overview:
- Round-robin arbiter and sequencer that shares the single SDRAM request port among four per-bank test engines (bank 0-3).
- Tracks per-bank access timeouts and tester-reported errors in sticky bad flags.
- The flags feed the video status screen directly on ba0_bad..ba3_bad.
- Sits between the bank testers and the SDRAM controller.

Parameters:
AW, 22, address width of one bank access (column+row)
TOUT, 1023, cycles allowed from grant to sdram_rdy before the access is declared timed out

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
dwnld_busy  input  1  high = no new grants; an in-flight access completes
ba_rd  input  4  per-bank read request, level; held until ba_rdy
ba_wr  input  4  per-bank write request, level; held until ba_rdy; rd and wr both high = write
ba_addr  input  4*AW  packed per-bank addresses, bank n at [n*AW +: AW]
ba_din  input  64  packed per-bank write data, bank n at [n*16 +: 16]
ba_err  input  4  per-bank compare-error pulse from testers
ba_rdy  output  4  one-cycle completion pulse to the granted bank
ba_dout  output  16  read data, valid with ba_rdy
ba0_bad, ba1_bad, ba2_bad, ba3_bad  output  1 each  sticky bank-bad flags
sdram_req  output  1  request to the SDRAM controller
sdram_we  output  1  1 = write
sdram_ba  output  2  bank select
sdram_addr  output  AW  address
sdram_din  output  16  write data
sdram_ack  input  1  request accepted (one cycle)
sdram_rdy  input  1  access finished; read data valid (one cycle)
sdram_dout  input  16  read data

Behaviour:
- Reset (async): state IDLE; all outputs 0; last-grant pointer = 3, so bank 0 wins first; timeout counter 0; bad flags cleared.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If !dwnld_busy and any (ba_rd|ba_wr) bit is set, grant the first requesting bank searching last+1, last+2, ... modulo 4.
  - On grant, latch bank, we, addr and din into sdram_* registers, set sdram_req=1, clear the counter, go to ISSUE.
  - Grant decision to sdram_req high takes one cycle.
- ISSUE:
  - Hold sdram_req and all sdram_* fields stable.
  - On sdram_ack, drop sdram_req the same edge and go to WAIT.
  - If sdram_ack and sdram_rdy arrive in the same cycle, complete directly as in WAIT.
- WAIT:
  - On sdram_rdy: ba_dout <= sdram_dout, pulse ba_rdy[bank] for one cycle, last <= bank, go to IDLE.
  - The earliest next grant is the cycle after the ba_rdy pulse, so a requester may deassert on seeing ba_rdy without being re-granted.
- Timeout:
  - The counter increments every cycle in ISSUE or WAIT.
  - When it reaches TOUT: set bad[bank], drop sdram_req, pulse ba_rdy[bank] with ba_dout=16'hFFFF, last <= bank, go to IDLE.
  - A later sdram_rdy/sdram_ack with no access pending is ignored.
- Bad flags: bad[n] is set by ba_err[n] at any time, in any state, or by a timeout. Both are cleared only by rst.
- Simultaneous events: a ba_err on a bank at the same edge as its timeout gives one set, no conflict. An sdram_rdy on the same cycle the counter hits TOUT counts as success; the flag is not set.
- dwnld_busy rising mid-access does not abort the access. It only blocks further grants.
- Request withdrawn while granted: the access still completes and ba_rdy still pulses.
- Widths: counter is ceil(log2(TOUT+1)) bits and saturates, never wraps. The pointer wraps 3 -> 0.

Test Plan:
- All four banks request reads continuously; sdram_ack 2 cycles after req, sdram_rdy 5 cycles later -> grants in order 0,1,2,3,0; ba_dout matches sdram_dout; exactly one ba_rdy pulse per access.
- Bank 2 write with addr 22'h12345, din 16'hA5C3 -> sdram_we=1, sdram_ba=2, sdram_addr=22'h12345, sdram_din=16'hA5C3, all stable until sdram_ack.
- Bank 1 read, sdram_rdy never arrives, TOUT=1023 -> ba_rdy[1] pulse 1023 cycles after grant, ba_dout=16'hFFFF, ba1_bad=1, others 0; next request granted normally.
- dwnld_busy raised during WAIT with banks 0 and 3 pending -> current access completes; no sdram_req until dwnld_busy falls; then bank 3 granted if last=2.
- ba_err[0] pulse in IDLE, then rst asserted mid-WAIT -> ba0_bad=1 before reset; on rst, sdram_req=0, all bad flags 0 immediately, next grant goes to bank 0.
- sdram_ack and sdram_rdy in the same cycle -> ba_rdy pulses the following edge; no extra cycle spent in WAIT.

Source files
------------

// File: rtl/jtsdram_bank_arb_if.sv
// jtsdram_bank_arb_if: bank-tester and SDRAM-controller signals of the bank arbiter
interface jtsdram_bank_arb_if #(
    parameter int AW = 22
);
    logic            dwnld_busy;
    logic [3:0]      ba_rd, ba_wr, ba_err, ba_rdy;
    logic [4*AW-1:0] ba_addr;
    logic [63:0]     ba_din;
    logic [15:0]     ba_dout;
    logic            ba0_bad, ba1_bad, ba2_bad, ba3_bad;
    logic            sdram_req, sdram_we, sdram_ack, sdram_rdy;
    logic [1:0]      sdram_ba;
    logic [AW-1:0]   sdram_addr;
    logic [15:0]     sdram_din, sdram_dout;

    modport master (
        input  dwnld_busy, ba_rd, ba_wr, ba_addr, ba_din, ba_err, sdram_ack, sdram_rdy, sdram_dout,
        output ba_rdy, ba_dout, ba0_bad, ba1_bad, ba2_bad, ba3_bad,
               sdram_req, sdram_we, sdram_ba, sdram_addr, sdram_din
    );

    modport slave (
        output dwnld_busy, ba_rd, ba_wr, ba_addr, ba_din, ba_err, sdram_ack, sdram_rdy, sdram_dout,
        input  ba_rdy, ba_dout, ba0_bad, ba1_bad, ba2_bad, ba3_bad,
               sdram_req, sdram_we, sdram_ba, sdram_addr, sdram_din
    );
endinterface

// File: rtl/jtsdram_bank_arb.sv
// jtsdram_bank_arb: round-robin arbiter sharing one SDRAM port among four bank testers,
// with per-bank access timeout and sticky bad flags.
module jtsdram_bank_arb #(
    parameter int AW   = 22,
    parameter int TOUT = 1023
) (
    input logic clk,
    input logic rst,
    jtsdram_bank_arb_if.master bus
);
    localparam int CW = $clog2(TOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        st;
    logic [1:0]    last, sel;
    logic [CW-1:0] cnt;
    logic [3:0]    bad, rq;
    logic          done, tmo;

    assign rq   = bus.ba_rd | bus.ba_wr;
    assign done = st == WAIT ? bus.sdram_rdy : st == ISSUE && bus.sdram_ack && bus.sdram_rdy;
    // a completion on the very cycle the limit is reached wins over the timeout
    assign tmo  = st != IDLE && !done && cnt == CW'(TOUT - 1);
    assign {bus.ba3_bad, bus.ba2_bad, bus.ba1_bad, bus.ba0_bad} = bad;

    // later assignments win, so the bank right after the last grant has top priority
    always_comb begin
        sel = last;
        for (int i = 4; i >= 1; i--)
            if (rq[2'(last + 2'(i))]) sel = 2'(last + 2'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st             <= IDLE;
            last           <= 2'd3;
            cnt            <= '0;
            bad            <= '0;
            bus.ba_rdy     <= '0;
            bus.ba_dout    <= '0;
            bus.sdram_req  <= 1'b0;
            bus.sdram_we   <= 1'b0;
            bus.sdram_ba   <= '0;
            bus.sdram_addr <= '0;
            bus.sdram_din  <= '0;
        end else begin
            bad        <= bad | bus.ba_err | (tmo ? 4'b1 << bus.sdram_ba : 4'b0);
            bus.ba_rdy <= '0;
            case (st)
                IDLE: if (!bus.dwnld_busy && |rq) begin
                    bus.sdram_ba   <= sel;
                    bus.sdram_we   <= bus.ba_wr[sel];
                    bus.sdram_addr <= bus.ba_addr[sel*AW +: AW];
                    bus.sdram_din  <= bus.ba_din[sel*16 +: 16];
                    bus.sdram_req  <= 1'b1;
                    cnt            <= '0;
                    st             <= ISSUE;
                end
                default: begin
                    cnt <= cnt == CW'(TOUT) ? cnt : cnt + 1'b1;
                    if (done || tmo) begin
                        bus.ba_dout   <= done ? bus.sdram_dout : 16'hFFFF;
                        bus.ba_rdy    <= 4'b1 << bus.sdram_ba;
                        last          <= bus.sdram_ba;
                        bus.sdram_req <= 1'b0;
                        st            <= IDLE;
                    end else if (st == ISSUE && bus.sdram_ack) begin
                        bus.sdram_req <= 1'b0;
                        st            <= WAIT;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtsdram_bank_arb.sv
// tb_jtsdram_bank_arb: randomized bench with a transaction-level model of grants,
// completion timing, timeouts and bad flags.
module tb_jtsdram_bank_arb;
    localparam int AW   = 22;
    localparam int TOUT = 1023;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    jtsdram_bank_arb_if #(.AW(AW)) bus ();
    jtsdram_bank_arb #(.AW(AW), .TOUT(TOUT)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    int checks = 0;
    int failures = 0;

    logic [3:0]    m_rd, m_wr, m_bad;
    logic [AW-1:0] m_addr [4];
    logic [15:0]   m_din  [4];
    int            m_last;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] bads;
        return {bus.ba3_bad, bus.ba2_bad, bus.ba1_bad, bus.ba0_bad};
    endfunction

    // next grant: first requester after the last served bank, going round the ring
    function automatic int rr(logic [3:0] rq, int last);
        for (int i = 1; i <= 4; i++)
            if (rq[(last + i) % 4]) return (last + i) % 4;
        return -1;
    endfunction

    task automatic drive_banks;
        bus.ba_rd = m_rd;
        bus.ba_wr = m_wr;
        for (int i = 0; i < 4; i++) begin
            bus.ba_addr[i*AW +: AW] = m_addr[i];
            bus.ba_din[i*16 +: 16]  = m_din[i];
        end
    endtask

    // mode: 0 drop, 1 read, 2 random read/write/both, 3 write
    task automatic new_req(input int b, input int mode);
        m_rd[b] = mode == 1 || (mode == 2 && $urandom_range(1) == 1);
        m_wr[b] = mode == 3 || (mode == 2 && $urandom_range(1) == 1);
        if (mode == 2 && !m_rd[b] && !m_wr[b]) m_rd[b] = 1'b1;
        m_addr[b] = AW'($urandom);
        m_din[b]  = 16'($urandom);
    endtask

    task automatic clear_reqs;
        for (int i = 0; i < 4; i++) new_req(i, 0);
        drive_banks();
    endtask

    task automatic grant_wait(input int exp_lat);
        int lat = 0;
        do begin
            step();
            lat++;
            checks++;
            if (bus.ba_rdy !== 4'b0) begin
                failures++;
                $display("FAIL idle_rdy got=%b exp=0000", bus.ba_rdy);
            end
        end while (bus.sdram_req !== 1'b1 && lat < 50);
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL grant_latency got=%0d exp=%0d", lat, exp_lat);
        end
    endtask

    // Serves one granted access: ack at sample a, rdy at sample r (r<0: never).
    task automatic serve(input int a, input int r, input int busy_k, input int mode,
                         input bit errs, output int gb);
        int b = rr(m_rd | m_wr, m_last);
        bit tmo = !(r >= 0 && r >= a && r + 1 <= TOUT);
        int d = tmo ? TOUT : r + 1;
        logic [15:0] rdat = 16'($urandom);
        logic exp_req;
        logic [3:0] exp_rdy;
        gb = b;
        checks++;
        if (b < 0) begin
            failures++;
            $display("FAIL model_no_requester got=%0d exp=0..3", b);
            return;
        end
        for (int k = 0; k <= d; k++) begin
            if (k > 0) step();
            if (k == d && tmo) m_bad[b] = 1'b1;
            exp_req = k <= a && k < d;
            exp_rdy = k == d ? 4'(1 << b) : 4'b0;
            checks++;
            if (bus.sdram_req !== exp_req) begin
                failures++;
                $display("FAIL sdram_req k=%0d got=%b exp=%b", k, bus.sdram_req, exp_req);
            end
            if (exp_req) begin
                checks++;
                if ({bus.sdram_ba, bus.sdram_we, bus.sdram_addr, bus.sdram_din} !==
                    {2'(b), m_wr[b], m_addr[b], m_din[b]}) begin
                    failures++;
                    $display("FAIL sdram_fields k=%0d got=%0d/%b/%h/%h exp=%0d/%b/%h/%h", k,
                             bus.sdram_ba, bus.sdram_we, bus.sdram_addr, bus.sdram_din,
                             b, m_wr[b], m_addr[b], m_din[b]);
                end
            end
            checks++;
            if (bus.ba_rdy !== exp_rdy) begin
                failures++;
                $display("FAIL ba_rdy k=%0d got=%b exp=%b", k, bus.ba_rdy, exp_rdy);
            end
            if (k == d) begin
                checks++;
                if (bus.ba_dout !== (tmo ? 16'hFFFF : rdat)) begin
                    failures++;
                    $display("FAIL ba_dout got=%h exp=%h", bus.ba_dout, tmo ? 16'hFFFF : rdat);
                end
            end
            checks++;
            if (bads() !== m_bad) begin
                failures++;
                $display("FAIL bad_flags k=%0d got=%b exp=%b", k, bads(), m_bad);
            end
            bus.sdram_ack  = k == a && k < d;
            bus.sdram_rdy  = k == r && k < d;
            bus.sdram_dout = k == r ? rdat : 16'($urandom);
            if (k == busy_k) bus.dwnld_busy = 1'b1;
            bus.ba_err = errs && k < d && $urandom_range(7) == 0 ? 4'(1 << $urandom_range(3)) : 4'b0;
            m_bad |= bus.ba_err;
        end
        m_last = b;
        new_req(b, mode);
        drive_banks();
    endtask

    task automatic test_reset;
        bus.dwnld_busy = 1'b0;
        bus.ba_err = '0;
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b0;
        bus.sdram_dout = '0;
        clear_reqs();
        m_bad = '0;
        m_last = 3;
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({bus.sdram_req, bus.sdram_we, bus.sdram_ba, bus.sdram_addr, bus.sdram_din} !== '0) begin
            failures++;
            $display("FAIL reset_sdram got=%b/%b/%0d/%h/%h exp=0", bus.sdram_req, bus.sdram_we,
                     bus.sdram_ba, bus.sdram_addr, bus.sdram_din);
        end
        checks++;
        if ({bus.ba_rdy, bus.ba_dout, bads()} !== '0) begin
            failures++;
            $display("FAIL reset_bank got=%b/%h/%b exp=0", bus.ba_rdy, bus.ba_dout, bads());
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin;
        int gb;
        int order [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) new_req(i, 1);
        drive_banks();
        for (int i = 0; i < 5; i++) begin
            grant_wait(1);
            serve(2, 7, -1, 1, 1'b0, gb);
            checks++;
            if (gb != order[i]) begin
                failures++;
                $display("FAIL rr_order i=%0d got=%0d exp=%0d", i, gb, order[i]);
            end
        end
        clear_reqs();
    endtask

    task automatic test_write_fields;
        int gb;
        new_req(2, 3);
        m_addr[2] = 22'h12345;
        m_din[2] = 16'hA5C3;
        drive_banks();
        grant_wait(1);
        checks++;
        if ({bus.sdram_we, bus.sdram_ba, bus.sdram_addr, bus.sdram_din} !== {1'b1, 2'd2, 22'h12345, 16'hA5C3}) begin
            failures++;
            $display("FAIL write_fields got=%b/%0d/%h/%h exp=1/2/12345/a5c3", bus.sdram_we,
                     bus.sdram_ba, bus.sdram_addr, bus.sdram_din);
        end
        serve(3, 5, -1, 0, 1'b0, gb);
    endtask

    task automatic test_ack_rdy_same;
        int gb;
        new_req(1, 1);
        drive_banks();
        grant_wait(1);
        serve(2, 2, -1, 0, 1'b0, gb);
    endtask

    task automatic test_timeout;
        int gb;
        new_req(1, 1);
        drive_banks();
        grant_wait(1);
        serve(2, -1, -1, 0, 1'b0, gb);
        checks++;
        if (bads() !== 4'b0010) begin
            failures++;
            $display("FAIL timeout_flags got=%b exp=0010", bads());
        end
        bus.sdram_ack = 1'b1;
        bus.sdram_rdy = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b0;
        step();
        checks++;
        if (bus.sdram_req !== 1'b0 || bus.ba_rdy !== 4'b0) begin
            failures++;
            $display("FAIL stray_rdy got=%b/%b exp=0/0000", bus.sdram_req, bus.ba_rdy);
        end
        new_req(0, 1);
        drive_banks();
        grant_wait(1);
        serve(1, 3, -1, 0, 1'b0, gb);
    endtask

    task automatic test_tout_edge;
        int gb;
        new_req(3, 1);
        drive_banks();
        grant_wait(1);
        serve(1, TOUT - 1, -1, 0, 1'b0, gb);
        checks++;
        if (bus.ba3_bad !== 1'b0) begin
            failures++;
            $display("FAIL tout_edge_flag got=%b exp=0", bus.ba3_bad);
        end
    endtask

    task automatic test_busy;
        int gb;
        new_req(1, 1);
        drive_banks();
        grant_wait(1);
        serve(1, 3, -1, 0, 1'b0, gb);
        new_req(0, 1);
        new_req(2, 1);
        new_req(3, 1);
        drive_banks();
        grant_wait(1);
        serve(1, 4, 3, 0, 1'b0, gb);
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (bus.sdram_req !== 1'b0) begin
                failures++;
                $display("FAIL busy_blocks i=%0d got=%b exp=0", i, bus.sdram_req);
            end
        end
        bus.dwnld_busy = 1'b0;
        grant_wait(1);
        serve(0, 2, -1, 0, 1'b0, gb);
        checks++;
        if (gb != 3) begin
            failures++;
            $display("FAIL busy_next got=%0d exp=3", gb);
        end
        grant_wait(1);
        serve(1, 1, -1, 0, 1'b0, gb);
    endtask

    task automatic test_random;
        int gb, a;
        new_req($urandom_range(3), 2);
        drive_banks();
        for (int n = 0; n < 30; n++) begin
            grant_wait(1);
            a = $urandom_range(3);
            serve(a, a + $urandom_range(4), -1, $urandom_range(1) == 1 ? 2 : 0, 1'b1, gb);
            for (int i = 0; i < 4; i++)
                if (!m_rd[i] && !m_wr[i] && $urandom_range(9) < 3) new_req(i, 2);
            if ((m_rd | m_wr) == 4'b0) new_req($urandom_range(3), 2);
            drive_banks();
        end
        clear_reqs();
    endtask

    task automatic test_reset_mid_wait;
        int gb;
        step();
        bus.ba_err = 4'b0001;
        step();
        bus.ba_err = 4'b0000;
        m_bad[0] = 1'b1;
        checks++;
        if (bus.ba0_bad !== 1'b1 || bads() !== m_bad) begin
            failures++;
            $display("FAIL err_sets_flag got=%b exp=%b", bads(), m_bad);
        end
        new_req(2, 1);
        drive_banks();
        grant_wait(1);
        serve(1, 2, -1, 1, 1'b0, gb);
        grant_wait(1);
        bus.sdram_ack = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.sdram_req !== 1'b0 || bads() !== 4'b0 || bus.ba_rdy !== 4'b0) begin
            failures++;
            $display("FAIL async_reset got=%b/%b/%b exp=0/0000/0000", bus.sdram_req, bads(), bus.ba_rdy);
        end
        m_last = 3;
        m_bad = '0;
        clear_reqs();
        step();
        rst = 1'b0;
        new_req(0, 1);
        new_req(3, 1);
        drive_banks();
        grant_wait(1);
        serve(1, 3, -1, 0, 1'b0, gb);
        checks++;
        if (gb != 0) begin
            failures++;
            $display("FAIL post_reset_grant got=%0d exp=0", gb);
        end
        grant_wait(1);
        serve(1, 3, -1, 0, 1'b0, gb);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_fields();
        test_ack_rdy_same();
        test_timeout();
        test_tout_edge();
        test_busy();
        test_random();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
